// File: rtl/pattern_pwr_seq_pkg.sv
// Shared types and helpers for the pattern index / rail power sequencer.
package pattern_pwr_seq_pkg;

    localparam int unsigned MS_W    = 16;
    localparam int unsigned PAT_MIN = 0;

    typedef enum logic [1:0] {
        PWR_OFF     = 2'd0,
        PWR_RAMP_UP = 2'd1,
        PWR_ON      = 2'd2,
        PWR_RAMP_DN = 2'd3
    } pwr_state_e;

    function automatic int unsigned pat_max(input int unsigned patnum);
        return patnum - 1;
    endfunction

endpackage

// File: rtl/ms_timer.sv
// One-shot millisecond timer: done pulses exactly len_ms*CNT1MS cycles after start.
module ms_timer
    import pattern_pwr_seq_pkg::*;
#(
    parameter int unsigned CNT1MS = 81000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [MS_W-1:0] len_ms,
    output logic            done
);

    localparam int unsigned   PW      = (CNT1MS > 1) ? $clog2(CNT1MS) : 1;
    localparam logic [PW-1:0] PRE_TOP = PW'((CNT1MS > 1) ? CNT1MS - 1 : 0);
    localparam logic [PW-1:0] PRE_LD  = PW'((CNT1MS > 1) ? CNT1MS - 2 : 0);
    localparam bit            SINGLE  = (CNT1MS <= 1);

    logic            running;
    logic [PW-1:0]   pre;
    logic [MS_W-1:0] ms;
    logic            instant;

    // The start cycle itself counts, so the load is one cycle short of a full period.
    assign instant = (len_ms == '0) || (SINGLE && (len_ms == MS_W'(1)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running <= 1'b0;
            done    <= 1'b0;
            pre     <= '0;
            ms      <= '0;
        end else if (start) begin
            done    <= instant;
            running <= !instant;
            ms      <= SINGLE ? len_ms - MS_W'(1) : len_ms;
            pre     <= PRE_LD;
        end else if (running) begin
            if (ms == MS_W'(1) && pre == '0) begin
                running <= 1'b0;
                done    <= 1'b1;
            end else begin
                done <= 1'b0;
                if (pre == '0) begin
                    pre <= PRE_TOP;
                    ms  <= ms - MS_W'(1);
                end else begin
                    pre <= pre - PW'(1);
                end
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// File: rtl/pattern_pwr_seq.sv
// Button-driven pattern index with key lock / auto-advance, and an ordered rail power sequencer.
module pattern_pwr_seq
    import pattern_pwr_seq_pkg::*;
#(
    parameter int unsigned PATNUM    = 9,
    parameter int unsigned SNW       = 7,
    parameter int unsigned NRAIL     = 6,
    parameter int unsigned NMUX      = 6,
    parameter int unsigned CNT1MS    = 81000,
    parameter int unsigned PWR_UP_MS = 500,
    parameter int unsigned PWR_DN_MS = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             key_up_n,
    input  logic             key_dn_n,
    input  logic             key_home_n,
    input  logic             key_ng_n,
    input  logic             auto_en,
    input  logic [MS_W-1:0]  lock_ms,
    output logic [SNW-1:0]   dis_sn,
    output logic             pat_chg,
    output logic [NRAIL-1:0] en_rail_n,
    output logic [NMUX-1:0]  mux_en,
    output logic             pwr_busy,
    output logic             flag_black,
    output logic             led_n
);

    localparam int unsigned    KW        = $clog2(NRAIL + 1);
    localparam logic [SNW-1:0] SN_MIN    = SNW'(PAT_MIN);
    localparam logic [SNW-1:0] SN_MAX    = SNW'(pat_max(PATNUM));
    localparam logic [SNW-1:0] SN_AUTO   = SNW'(pat_max(PATNUM) - 2);
    localparam logic [KW-1:0]  K_FULL    = KW'(NRAIL);

    logic [3:0]      key_q;
    logic [3:0]      key_fall;
    logic [SNW-1:0]  sn_nxt;
    logic            lock_done;
    logic            lock_expired;
    logic            up_req;
    logic            dn_req;

    pwr_state_e      state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [NRAIL-1:0] rail_nxt;
    logic            step_start;
    logic [MS_W-1:0] step_len;
    logic            step_done;

    // Key order in key_q: {home, ng, up, dn}; a falling level is one press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) key_q <= 4'hF;
        else        key_q <= {key_home_n, key_ng_n, key_up_n, key_dn_n};
    end

    assign key_fall     = key_q & ~{key_home_n, key_ng_n, key_up_n, key_dn_n};
    assign lock_expired = lock_done && !pat_chg;

    always_comb begin
        sn_nxt = dis_sn;
        if (key_fall[3]) begin
            sn_nxt = SN_MIN;
        end else if (key_fall[2]) begin
            sn_nxt = SN_MAX;
        end else if (key_fall[1] && led_n) begin
            if (dis_sn != SN_MAX) sn_nxt = dis_sn + SNW'(1);
        end else if (key_fall[0] && led_n) begin
            if (dis_sn != SN_MIN && dis_sn != SN_MAX) sn_nxt = dis_sn - SNW'(1);
        end else if (lock_expired && auto_en && dis_sn >= SNW'(1) && dis_sn <= SN_AUTO) begin
            sn_nxt = dis_sn + SNW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dis_sn     <= SN_MIN;
            pat_chg    <= 1'b0;
            flag_black <= 1'b1;
            up_req     <= 1'b0;
            dn_req     <= 1'b0;
            led_n      <= 1'b1;
        end else begin
            dis_sn     <= sn_nxt;
            pat_chg    <= (sn_nxt != dis_sn);
            flag_black <= (sn_nxt == SN_MIN) || (sn_nxt == SN_MAX);
            up_req     <= (dis_sn == SN_MIN) && (sn_nxt == SNW'(1));
            dn_req     <= (sn_nxt != dis_sn) && ((sn_nxt == SN_MIN) || (sn_nxt == SN_MAX));
            if (pat_chg)           led_n <= 1'b0;
            else if (lock_expired) led_n <= 1'b1;
        end
    end

    ms_timer #(.CNT1MS(CNT1MS)) u_lock_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (pat_chg),
        .len_ms (lock_ms),
        .done   (lock_done)
    );

    ms_timer #(.CNT1MS(CNT1MS)) u_step_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (step_start),
        .len_ms (step_len),
        .done   (step_done)
    );

    // Power sequencer: k is the number of rails currently on (rails 0..k-1).
    always_comb begin
        state_nxt  = state;
        k_nxt      = k;
        step_start = 1'b0;
        case (state)
            PWR_OFF: begin
                if (up_req) begin
                    state_nxt  = PWR_RAMP_UP;
                    k_nxt      = KW'(1);
                    step_start = 1'b1;
                end
            end
            PWR_RAMP_UP, PWR_ON: begin
                if (dn_req) begin
                    k_nxt      = k - KW'(1);
                    state_nxt  = (k_nxt == '0) ? PWR_OFF : PWR_RAMP_DN;
                    step_start = (k_nxt != '0);
                end else if (state == PWR_RAMP_UP && step_done) begin
                    if (k == K_FULL) begin
                        state_nxt = PWR_ON;
                    end else begin
                        k_nxt      = k + KW'(1);
                        step_start = 1'b1;
                    end
                end
            end
            PWR_RAMP_DN: begin
                if (up_req) begin
                    state_nxt  = PWR_RAMP_UP;
                    k_nxt      = k + KW'(1);
                    step_start = 1'b1;
                end else if (step_done) begin
                    k_nxt      = k - KW'(1);
                    state_nxt  = (k_nxt == '0) ? PWR_OFF : PWR_RAMP_DN;
                    step_start = (k_nxt != '0);
                end
            end
            default: state_nxt = PWR_OFF;
        endcase
        step_len = (state_nxt == PWR_RAMP_DN) ? MS_W'(PWR_DN_MS) : MS_W'(PWR_UP_MS);
        rail_nxt = '1;
        for (int i = 0; i < NRAIL; i++) rail_nxt[i] = (KW'(i) >= k_nxt);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= PWR_OFF;
            k         <= '0;
            en_rail_n <= '1;
            mux_en    <= '0;
            pwr_busy  <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            en_rail_n <= rail_nxt;
            mux_en    <= {NMUX{state_nxt == PWR_ON}};
            pwr_busy  <= (state_nxt == PWR_RAMP_UP) || (state_nxt == PWR_RAMP_DN);
        end
    end

endmodule

// File: tb/tb_pattern_pwr_seq.sv
// Directed bench for pattern_pwr_seq with a small, fast parameter set.
module tb_pattern_pwr_seq;

    logic        clk;
    logic        rst_n;
    logic        key_up_n, key_dn_n, key_home_n, key_ng_n;
    logic        auto_en;
    logic [15:0] lock_ms;
    logic [6:0]  dis_sn;
    logic        pat_chg;
    logic [2:0]  en_rail_n;
    logic [1:0]  mux_en;
    logic        pwr_busy, flag_black, led_n;

    int total = 0;
    int bad   = 0;
    int cnt;

    pattern_pwr_seq #(
        .PATNUM(5), .SNW(7), .NRAIL(3), .NMUX(2),
        .CNT1MS(4), .PWR_UP_MS(2), .PWR_DN_MS(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_up_n   (key_up_n),
        .key_dn_n   (key_dn_n),
        .key_home_n (key_home_n),
        .key_ng_n   (key_ng_n),
        .auto_en    (auto_en),
        .lock_ms    (lock_ms),
        .dis_sn     (dis_sn),
        .pat_chg    (pat_chg),
        .en_rail_n  (en_rail_n),
        .mux_en     (mux_en),
        .pwr_busy   (pwr_busy),
        .flag_black (flag_black),
        .led_n      (led_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic release_keys();
        key_up_n = 1'b1; key_dn_n = 1'b1; key_home_n = 1'b1; key_ng_n = 1'b1;
    endtask

    task automatic do_reset(input logic [15:0] lk, input logic au);
        rst_n   = 1'b0;
        release_keys();
        lock_ms = lk;
        auto_en = au;
        step(2);
        rst_n = 1'b1;
        step(1);
    endtask

    // keys = {home, ng, up, dn}; one press, then enough idle cycles for a zero-length lock.
    task automatic press(input logic [3:0] keys);
        {key_home_n, key_ng_n, key_up_n, key_dn_n} = ~keys;
        step(1);
        release_keys();
        step(3);
    endtask

    initial begin
        // 1: reset values and key lock
        do_reset(16'd3, 1'b0);
        check("rst_dis_sn", dis_sn, 0);
        check("rst_pat_chg", pat_chg, 0);
        check("rst_rail", en_rail_n, 3'b111);
        check("rst_mux", mux_en, 2'b00);
        check("rst_busy", pwr_busy, 0);
        check("rst_black", flag_black, 1);
        check("rst_led", led_n, 1);
        key_up_n = 1'b0;
        step(1);
        check("t1_dis1", dis_sn, 1);
        check("t1_pat_chg", pat_chg, 1);
        check("t1_black", flag_black, 0);
        key_up_n = 1'b1;
        cnt = 0;
        for (int i = 1; i <= 20; i++) begin
            if (i == 5) key_up_n = 1'b0;
            if (i == 7) key_up_n = 1'b1;
            step(1);
            if (!led_n) cnt++;
        end
        check("t1_lock_len", cnt, 12);
        check("t1_dropped", dis_sn, 1);
        key_up_n = 1'b0;
        step(1);
        check("t1_dis2", dis_sn, 2);
        key_up_n = 1'b1;

        // 2: power-up sequence
        do_reset(16'd0, 1'b0);
        key_up_n = 1'b0;
        step(1);
        check("t2_dis1", dis_sn, 1);
        key_up_n = 1'b1;
        step(1);
        check("t2_rail0", en_rail_n, 3'b110);
        check("t2_busy", pwr_busy, 1);
        step(7);
        check("t2_rail0_hold", en_rail_n, 3'b110);
        step(1);
        check("t2_rail1", en_rail_n, 3'b100);
        step(7);
        check("t2_rail1_hold", en_rail_n, 3'b100);
        step(1);
        check("t2_rail2", en_rail_n, 3'b000);
        step(7);
        check("t2_mux_pre", mux_en, 2'b00);
        step(1);
        check("t2_mux_on", mux_en, 2'b11);
        check("t2_busy_off", pwr_busy, 0);

        // 3: power-down from ON
        key_ng_n = 1'b0;
        step(1);
        check("t3_dis4", dis_sn, 4);
        check("t3_black", flag_black, 1);
        key_ng_n = 1'b1;
        step(1);
        check("t3_mux_off", mux_en, 2'b00);
        check("t3_rail_100", en_rail_n, 3'b100);
        check("t3_busy", pwr_busy, 1);
        step(3);
        check("t3_rail_hold", en_rail_n, 3'b100);
        step(1);
        check("t3_rail_110", en_rail_n, 3'b110);
        step(4);
        check("t3_rail_111", en_rail_n, 3'b111);
        check("t3_busy_off", pwr_busy, 0);

        // 4: down request during ramp-up
        do_reset(16'd0, 1'b0);
        key_up_n = 1'b0;
        step(1);
        key_up_n = 1'b1;
        step(9);
        check("t4_rail_100", en_rail_n, 3'b100);
        key_ng_n = 1'b0;
        step(1);
        check("t4_dis4", dis_sn, 4);
        key_ng_n = 1'b1;
        step(1);
        check("t4_rail_110", en_rail_n, 3'b110);
        step(3);
        check("t4_rail_hold", en_rail_n, 3'b110);
        step(1);
        check("t4_rail_111", en_rail_n, 3'b111);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (mux_en != 2'b00 || en_rail_n != 3'b111) cnt++;
        end
        check("t4_never_on", cnt, 0);
        check("t4_busy_off", pwr_busy, 0);

        // 5: home beats up; held key does not repeat
        do_reset(16'd0, 1'b0);
        press(4'b0010);
        step(22);
        check("t5_on", mux_en, 2'b11);
        press(4'b0010);
        press(4'b0010);
        check("t5_dis3", dis_sn, 3);
        key_home_n = 1'b0;
        key_up_n   = 1'b0;
        step(1);
        check("t5_home", dis_sn, 0);
        release_keys();
        step(1);
        check("t5_mux_off", mux_en, 2'b00);
        check("t5_rail_100", en_rail_n, 3'b100);
        step(4);
        check("t5_rail_110", en_rail_n, 3'b110);
        step(4);
        check("t5_rail_111", en_rail_n, 3'b111);
        check("t5_up_lost", dis_sn, 0);
        key_up_n = 1'b0;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            step(1);
            if (pat_chg) cnt++;
        end
        key_up_n = 1'b1;
        check("t5_hold_chg", cnt, 1);
        check("t5_hold_dis", dis_sn, 1);

        // 6: auto-advance, then asynchronous reset mid ramp-up
        do_reset(16'd1, 1'b1);
        key_up_n = 1'b0;
        step(1);
        check("t6_dis1", dis_sn, 1);
        key_up_n = 1'b1;
        step(4);
        check("t6_dis1_hold", dis_sn, 1);
        step(1);
        check("t6_dis2", dis_sn, 2);
        step(5);
        check("t6_dis3", dis_sn, 3);
        step(6);
        check("t6_stop3", dis_sn, 3);
        check("t6_rail_100", en_rail_n, 3'b100);
        check("t6_busy", pwr_busy, 1);
        rst_n = 1'b0;
        #2;
        check("t6_arst_rail", en_rail_n, 3'b111);
        check("t6_arst_mux", mux_en, 2'b00);
        check("t6_arst_busy", pwr_busy, 0);
        check("t6_arst_dis", dis_sn, 0);
        check("t6_arst_black", flag_black, 1);
        step(1);

        // 7: saturation and ignored down presses at the ends
        do_reset(16'd0, 1'b0);
        press(4'b0001);
        check("t7_dn_at_min", dis_sn, 0);
        press(4'b0100);
        check("t7_ng", dis_sn, 4);
        press(4'b0010);
        check("t7_up_sat", dis_sn, 4);
        press(4'b0001);
        check("t7_dn_at_max", dis_sn, 4);
        press(4'b1000);
        check("t7_home", dis_sn, 0);
        check("t7_black_min", flag_black, 1);
        press(4'b0010);
        press(4'b0010);
        press(4'b0001);
        check("t7_dn", dis_sn, 1);
        check("t7_black_mid", flag_black, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
